// File: rtl/laser_pkg.sv
// Shared types and constants for the laser distance display: FSM states, widths,
// seven-segment patterns and the double-dabble step.
package laser_pkg;

  typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;

  localparam int unsigned BCD_DIGITS = 5;
  localparam int unsigned DIST_W     = 16;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam int unsigned SR_W       = BCD_W + DIST_W;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // One iteration: add 3 to every BCD nibble >= 5, then shift the whole register left
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] t;
    t = sr;
    for (int unsigned k = 0; k < BCD_DIGITS; k++) begin
      if (t[DIST_W + 4*k +: 4] >= 4'd5)
        t[DIST_W + 4*k +: 4] = t[DIST_W + 4*k +: 4] + 4'd3;
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 16 iterations per conversion, result
// published to bcd only when the conversion completes.
module bin2bcd_seq
  import laser_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIST_W-1:0] bin,
  output logic [BCD_W-1:0]  bcd,
  output logic              busy
);

  conv_state_t     state;
  logic [SR_W-1:0] sr;
  logic [3:0]      iter;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      iter  <= '0;
      bcd   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= {{BCD_W{1'b0}}, bin};
            iter  <= '0;
            state <= CONV;
            busy  <= 1'b1;
          end
        end
        CONV: begin
          sr <= dabble_step(sr);
          if (iter == 4'd15) state <= DONE;
          else               iter  <= iter + 4'd1;
        end
        DONE: begin
          bcd   <= sr[SR_W-1 -: BCD_W];
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/laser_dist_display.sv
// Display stage for the laser distance measurer: converts D to BCD on change and
// scans five active-low digits. Define LASER_DISP_BLANK_EN to blank leading zeros.
module laser_dist_display
  import laser_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIST_W-1:0] D,
  output logic [6:0]        seg,
  output logic [4:0]        an,
  output logic [BCD_W-1:0]  bcd,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  logic [DIST_W-1:0] d_last;
  logic              start;
  logic [CNT_W-1:0]  refresh_cnt;
  logic [2:0]        idx;
  logic [3:0]        digit;
  logic [6:0]        seg_nxt;
  logic [4:0]        an_nxt;

  // The converter only accepts start in IDLE, where busy is low
  assign start = (D != d_last) && !busy;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (D),
    .bcd   (bcd),
    .busy  (busy)
  );

  always_comb begin
    digit   = bcd[{idx, 2'b00} +: 4];
    seg_nxt = seg_of(digit);
`ifdef LASER_DISP_BLANK_EN
    if (idx != 3'd0 && (bcd >> {idx, 2'b00}) == '0) seg_nxt = SEG_BLANK;
`endif
    an_nxt = ~(5'(1) << idx);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_last      <= '0;
      refresh_cnt <= '0;
      idx         <= '0;
      seg         <= SEG_BLANK;
      an          <= '1;
    end else begin
      if (start) d_last <= D;
      if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        idx         <= (idx == 3'(BCD_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_laser_dist_display.sv
// Self-checking bench for laser_dist_display against a decimal-arithmetic reference model.
module tb_laser_dist_display;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] D = '0;
  logic [6:0]  seg;
  logic [4:0]  an;
  logic [19:0] bcd;
  logic        busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned ncyc     = 0;   // edges since reset release
  int unsigned cur      = 0;   // value the display should show
  int unsigned last     = 0;   // model of the last captured D

  laser_dist_display #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .D     (D),
    .seg   (seg),
    .an    (an),
    .bcd   (bcd),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ncyc <= rst_n ? ncyc + 1 : 0;

  function automatic int unsigned pow10(input int unsigned k);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [19:0] bcd_of(input int unsigned v);
    logic [19:0] r;
    r = '0;
    for (int unsigned k = 0; k < 5; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic logic [6:0] seg_tab(input int unsigned d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] disp_seg(input int unsigned v, input int unsigned k);
`ifdef LASER_DISP_BLANK_EN
    if (k != 0 && v / pow10(k) == 0) return 7'h7F;
`endif
    return seg_tab((v / pow10(k)) % 10);
  endfunction

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full conversion from IDLE with v != last; checks latency and busy window
  task automatic convert(input int unsigned v);
    D = v[15:0];
    step();
    check("busy_rise", busy, 1);
    repeat (16) step();
    check("busy_hold", busy, 1);
    check("bcd_hold", bcd, bcd_of(cur));
    step();
    check("bcd_done", bcd, bcd_of(v));
    check("busy_fall", busy, 0);
    last = v;
    cur  = v;
  endtask

  // D changes to v2 after conversion edge 'at' of v1
  task automatic conv_interrupt(input int unsigned v1, input int unsigned v2, input int unsigned at);
    D = v1[15:0];
    step();
    repeat (at) step();
    D = v2[15:0];
    repeat (17 - at) step();
    check("int_bcd1", bcd, bcd_of(v1));
    check("int_gap", busy, 0);
    step();
    check("int_restart", busy, 1);
    repeat (16) step();
    check("int_hold", bcd, bcd_of(v1));
    step();
    check("int_bcd2", bcd, bcd_of(v2));
    check("int_busy_end", busy, 0);
    last = v2;
    cur  = v2;
  endtask

  task automatic scan(input int unsigned cycles);
    int unsigned k;
    for (int unsigned i = 0; i < cycles; i++) begin
      step();
      k = ((ncyc - 1) / DIV) % 5;
      check("an", an, 5'h1F & ~(5'd1 << k));
      check("seg", seg, disp_seg(cur, k));
    end
  endtask

  initial begin
    int unsigned v, v2, at;

    // Reset with a nonzero input, then first conversion
    rst_n = 1'b0;
    D = 16'd1234;
    repeat (3) step();
    check("rst_seg", seg, 7'h7F);
    check("rst_an", an, 5'h1F);
    check("rst_bcd", bcd, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    convert(1234);
    scan(45);

    convert(65535);
    convert(0);
    scan(10);

    conv_interrupt(100, 200, 5);
    scan(12);

    convert(42);
    scan(45);
    convert(0);
    scan(25);

    // Reset mid-conversion
    D = 16'd999;
    step();
    repeat (8) step();
    rst_n = 1'b0;
    repeat (2) step();
    check("abort_bcd", bcd, 0);
    check("abort_busy", busy, 0);
    check("abort_seg", seg, 7'h7F);
    check("abort_an", an, 5'h1F);
    last = 0;
    cur  = 0;
    rst_n = 1'b1;
    convert(999);
    scan(25);

    for (int i = 0; i < 10; i++) begin
      v = ($urandom % 2 == 0) ? $urandom_range(0, 150) : $urandom_range(0, 65535);
      if (v == last) v = (v + 1) % 65536;
      convert(v);
      scan(DIV * 5 + 3);
    end

    for (int i = 0; i < 4; i++) begin
      v = $urandom_range(0, 65535);
      if (v == last) v = (v + 7) % 65536;
      v2 = $urandom_range(0, 65535);
      if (v2 == v) v2 = (v2 + 3) % 65536;
      at = $urandom_range(1, 16);
      conv_interrupt(v, v2, at);
      scan(DIV * 5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
